// File: rtl/k7_pkg.sv
// Shared types and defaults for the tape SDRAM loader.
// The write FIFO entry layout and the scheduler state enum live here.
package k7_pkg;

    localparam int unsigned K7_ADDR_W     = 23;
    localparam logic [7:0]  K7_TAPE_INDEX = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [K7_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } wr_entry_t;

    localparam int unsigned K7_ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/k7_sdram_loader_if.sv
// Byte-wide request/ready port towards the shared SDRAM controller.
interface k7_sdram_loader_if #(
    parameter int unsigned ADDR_W = 23
);
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic              we;
    logic              rd;
    logic [7:0]        dout;
    logic              ready;

    modport master (output addr, din, we, rd, input dout, ready);
    modport slave  (input addr, din, we, rd, output dout, ready);
endinterface

// File: rtl/k7_wr_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module k7_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // A push while full is only issued together with a pop, so it lands in the slot being freed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_W-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head  = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/k7_sdram_loader.sv
// Streams tape downloads into SDRAM via a write FIFO and serves cassette byte reads,
// with writes always taking priority over reads on the shared port.
module k7_sdram_loader
    import k7_pkg::*;
#(
    parameter int unsigned ADDR_W     = K7_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  TAPE_INDEX = K7_TAPE_INDEX
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              tape_rd,
    input  logic [ADDR_W-1:0] tape_addr,
    output logic [7:0]        tape_data,
    output logic              tape_valid,
    k7_sdram_loader_if.master sdram,
    output logic [ADDR_W-1:0] tape_len,
    output logic              tape_loaded,
    output logic              loading,
    output logic              overflow
);
    logic        dl_q;
    logic        tape_act;
    logic        done;
    logic        rise_c;
    logic        fall_c;
    logic        start_c;
    logic        act_c;
    logic        wr_c;
    logic        oob_c;
    logic        push_c;
    logic        pop_c;
    logic        fifo_full;
    logic        fifo_empty;
    wr_entry_t   fifo_din;
    wr_entry_t   fifo_head;

    logic [ADDR_W:0]   len_inc_c;
    logic [ADDR_W-1:0] len_sat_c;
    logic [ADDR_W-1:0] len_base_c;

    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_take_c;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        din_n;
    logic              we_n;
    logic              rd_n;
    logic [7:0]        data_n;
    logic              valid_n;

    // Download window: the select decision is taken on the rising edge of ioctl_download.
    assign rise_c  = ioctl_download & ~dl_q;
    assign fall_c  = ~ioctl_download & dl_q;
    assign start_c = rise_c & (ioctl_index == TAPE_INDEX);
    assign act_c   = ioctl_download & (rise_c ? (ioctl_index == TAPE_INDEX) : tape_act);

    assign wr_c   = ioctl_wr & act_c;
    assign oob_c  = (ioctl_addr >> ADDR_W) != '0;
    assign pop_c  = (state == ST_WR) & sdram.ready;
    assign push_c = wr_c & ~oob_c & (~fifo_full | pop_c);

    assign fifo_din.addr = K7_ADDR_W'(ioctl_addr[ADDR_W-1:0]);
    assign fifo_din.data = ioctl_dout;

    assign len_inc_c  = (ADDR_W+1)'(ioctl_addr[ADDR_W-1:0]) + (ADDR_W+1)'(1);
    assign len_sat_c  = len_inc_c[ADDR_W] ? '1 : len_inc_c[ADDR_W-1:0];
    assign len_base_c = start_c ? '0 : tape_len;

    assign loading = tape_act | ~fifo_empty;

    k7_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (K7_ENTRY_W)
    ) u_fifo (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .push    (push_c),
        .pop     (pop_c),
        .din     (fifo_din),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Download bookkeeping: length, overflow and completion status.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dl_q        <= 1'b0;
            tape_act    <= 1'b0;
            done        <= 1'b0;
            tape_len    <= '0;
            tape_loaded <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            dl_q     <= ioctl_download;
            tape_act <= act_c;
            overflow <= (overflow & ~start_c) | (wr_c & ~push_c);
            if (push_c && (len_sat_c > len_base_c)) tape_len <= len_sat_c;
            else                                    tape_len <= len_base_c;
            if (start_c) begin
                done        <= 1'b0;
                tape_loaded <= 1'b0;
            end else if (fall_c && tape_act) begin
                done <= 1'b1;
            end else if (done && fifo_empty && (state == ST_IDLE)) begin
                tape_loaded <= 1'b1;
            end
        end
    end

    // Pending read: latest request wins; taken when the read is launched.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (tape_rd) begin
            pend      <= 1'b1;
            pend_addr <= tape_addr;
        end else if (pend_take_c) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sdram.addr <= '0;
            sdram.din  <= '0;
            sdram.we   <= 1'b0;
            sdram.rd   <= 1'b0;
            tape_data  <= '0;
            tape_valid <= 1'b0;
        end else begin
            state      <= state_n;
            sdram.addr <= addr_n;
            sdram.din  <= din_n;
            sdram.we   <= we_n;
            sdram.rd   <= rd_n;
            tape_data  <= data_n;
            tape_valid <= valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = sdram.addr;
        din_n       = sdram.din;
        we_n        = sdram.we;
        rd_n        = sdram.rd;
        data_n      = tape_data;
        valid_n     = 1'b0;
        pend_take_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_n = ST_WR;
                    addr_n  = ADDR_W'(fifo_head.addr);
                    din_n   = fifo_head.data;
                    we_n    = 1'b1;
                end else if (pend && !act_c) begin
                    state_n     = ST_RD;
                    addr_n      = pend_addr;
                    rd_n        = 1'b1;
                    pend_take_c = 1'b1;
                end
            end
            ST_WR: begin
                if (sdram.ready) begin
                    we_n    = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_RD: begin
                if (sdram.ready) begin
                    data_n  = sdram.dout;
                    valid_n = 1'b1;
                    rd_n    = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                we_n    = 1'b0;
                rd_n    = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_k7_sdram_loader.sv
// Randomized scoreboard bench for k7_sdram_loader with a behavioural SDRAM and loader model.
module tb_k7_sdram_loader;
    import k7_pkg::*;

    localparam int unsigned AW    = 23;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } xfer_t;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          tape_rd;
    logic [AW-1:0] tape_addr;
    logic [7:0]    tape_data;
    logic          tape_valid;
    logic [AW-1:0] tape_len;
    logic          tape_loaded;
    logic          loading;
    logic          overflow;

    k7_sdram_loader_if #(.ADDR_W(AW)) sdram_bus ();

    k7_sdram_loader #(
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .TAPE_INDEX (8'd1)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .tape_rd        (tape_rd),
        .tape_addr      (tape_addr),
        .tape_data      (tape_data),
        .tape_valid     (tape_valid),
        .sdram          (sdram_bus),
        .tape_len       (tape_len),
        .tape_loaded    (tape_loaded),
        .loading        (loading),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int lat   = 3;
    logic rdy_is_wr = 1'b0;
    logic prev_v    = 1'b0;

    xfer_t exp_wr[$];
    xfer_t exp_rd[$];
    logic [7:0] ref_mem [int];
    logic [7:0] smem [int];

    logic          m_dl_q = 1'b0;
    logic          m_act  = 1'b0;
    logic          m_done = 1'b0;
    logic          m_ovf  = 1'b0;
    int            m_cnt  = 0;
    logic [AW-1:0] m_len  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: acceptance decided from FIFO occupancy, tracked by pushes and write completions.
    initial begin
        logic rise, fall, act, pop;
        int unsigned nl;
        xfer_t e;
        forever begin
            @(posedge clk_sys);
            if (!reset_n) begin
                m_dl_q = 1'b0; m_act = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
                m_cnt = 0; m_len = '0;
                exp_wr.delete();
            end else begin
                rise = ioctl_download && !m_dl_q;
                fall = !ioctl_download && m_dl_q;
                act  = ioctl_download && (rise ? (ioctl_index == 8'd1) : m_act);
                pop  = sdram_bus.ready && rdy_is_wr;
                if (rise && ioctl_index == 8'd1) begin
                    m_len = '0; m_ovf = 1'b0; m_done = 1'b0;
                end
                if (ioctl_wr && act) begin
                    if (ioctl_addr > 25'h7FFFFF || (m_cnt == DEPTH && !pop)) begin
                        m_ovf = 1'b1;
                    end else begin
                        e.addr = ioctl_addr[AW-1:0];
                        e.data = ioctl_dout;
                        exp_wr.push_back(e);
                        ref_mem[int'(e.addr)] = e.data;
                        m_cnt++;
                        nl = 32'(e.addr) + 1;
                        if (nl > 32'h7FFFFF) nl = 32'h7FFFFF;
                        if (nl > 32'(m_len)) m_len = AW'(nl);
                    end
                end
                if (pop) m_cnt--;
                if (fall && m_act) m_done = 1'b1;
                m_act  = act;
                m_dl_q = ioctl_download;
            end
        end
    end

    // SDRAM model: answers each request after lat cycles and scores writes and read addresses.
    initial begin
        int cnt;
        logic [AW-1:0] cap;
        xfer_t e;
        cnt = 0;
        cap = '0;
        sdram_bus.ready = 1'b0;
        sdram_bus.dout  = 8'h00;
        forever begin
            @(negedge clk_sys);
            if (sdram_bus.ready) begin
                sdram_bus.ready = 1'b0;
                rdy_is_wr = 1'b0;
                cnt = 0;
            end else if (!reset_n || !(sdram_bus.we || sdram_bus.rd)) begin
                cnt = 0;
            end else begin
                if (cnt == 0) cap = sdram_bus.addr;
                else chk("req_hold", 32'(sdram_bus.addr), 32'(cap));
                cnt++;
                if (cnt >= lat) begin
                    sdram_bus.ready = 1'b1;
                    rdy_is_wr = sdram_bus.we;
                    if (sdram_bus.we) begin
                        smem[int'(sdram_bus.addr)] = sdram_bus.din;
                        if (exp_wr.size() == 0) begin
                            total++; bad++;
                            $display("FAIL wr_unexpected: got write at %0h required none", sdram_bus.addr);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", 32'(sdram_bus.addr), 32'(e.addr));
                            chk("wr_data", 32'(sdram_bus.din), 32'(e.data));
                        end
                    end else begin
                        sdram_bus.dout = smem.exists(int'(sdram_bus.addr)) ? smem[int'(sdram_bus.addr)] : 8'h00;
                        if (exp_rd.size() == 0) begin
                            total++; bad++;
                            $display("FAIL rd_unexpected: got read at %0h required none", sdram_bus.addr);
                        end else begin
                            chk("rd_addr", 32'(sdram_bus.addr), 32'(exp_rd[0].addr));
                        end
                    end
                    cnt = 0;
                end
            end
        end
    end

    // Read-return monitor.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk_sys);
            if (reset_n && tape_valid) begin
                chk("valid_pulse", 32'(prev_v), 32'(0));
                chk("wr_before_rd", 32'(exp_wr.size()), 32'(0));
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_return_unexpected: got data %0h required none", tape_data);
                end else begin
                    e = exp_rd.pop_front();
                    chk("rd_data", 32'(tape_data), 32'(e.data));
                end
            end
            prev_v = tape_valid;
        end
    end

    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        step();
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step();
    endtask

    task automatic end_dl();
        step();
        ioctl_download = 1'b0;
        step();
    endtask

    task automatic send(input logic [24:0] a, input int gap);
        step();
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = 8'($urandom_range(0, 255));
        step();
        ioctl_wr = 1'b0;
        repeat (gap - 2) step();
    endtask

    task automatic burst(input logic [24:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            ioctl_wr   = 1'b1;
            ioctl_addr = base + 25'(i);
            ioctl_dout = 8'($urandom_range(0, 255));
        end
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic req_read(input logic [AW-1:0] a);
        step();
        tape_rd   = 1'b1;
        tape_addr = a;
        step();
        tape_rd = 1'b0;
    endtask

    task automatic expect_read(input logic [AW-1:0] a);
        xfer_t e;
        e.addr = a;
        e.data = ref_mem[int'(a)];
        exp_rd.push_back(e);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (n < 3000 && !(m_cnt == 0 && exp_rd.size() == 0 && !sdram_bus.we &&
                             !sdram_bus.rd && !tape_valid)) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL quiet_timeout: got %0d pending writes required 0", m_cnt);
        end
        repeat (4) step();
    endtask

    task automatic check_status(input logic exp_loading);
        chk("tape_len", 32'(tape_len), 32'(m_len));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("tape_loaded", 32'(tape_loaded), 32'(m_done));
        chk("loading", 32'(loading), 32'(exp_loading));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 32'(sdram_bus.we), 32'(0));
        chk({tag, "_rd"}, 32'(sdram_bus.rd), 32'(0));
        chk({tag, "_addr"}, 32'(sdram_bus.addr), 32'(0));
        chk({tag, "_din"}, 32'(sdram_bus.din), 32'(0));
        chk({tag, "_tdata"}, 32'(tape_data), 32'(0));
        chk({tag, "_tvalid"}, 32'(tape_valid), 32'(0));
        chk({tag, "_len"}, 32'(tape_len), 32'(0));
        chk({tag, "_loaded"}, 32'(tape_loaded), 32'(0));
        chk({tag, "_loading"}, 32'(loading), 32'(0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(0));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; tape_rd = 1'b0; tape_addr = '0;
        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Paced 16-byte load.
        lat = 3;
        start_dl(8'd1);
        for (int i = 0; i < 16; i++) send(25'(i), 8);
        end_dl();
        wait_quiet();
        chk("len16", 32'(tape_len), 32'd16);
        check_status(1'b0);

        // Back-to-back bytes overrun the FIFO; one out-of-range address is dropped too.
        lat = 5;
        start_dl(8'd1);
        send(25'h1000005, 4);
        burst(25'd100, 8);
        end_dl();
        wait_quiet();
        chk("ovf_set", 32'(overflow), 32'd1);
        check_status(1'b0);

        // Foreign download slot is ignored.
        start_dl(8'd2);
        for (int i = 0; i < 4; i++) send(25'(200 + i), 3);
        end_dl();
        wait_quiet();
        check_status(1'b0);

        // Reload, then a single read.
        lat = 3;
        start_dl(8'd1);
        for (int i = 0; i < 16; i++) send(25'(i), 3);
        end_dl();
        wait_quiet();
        check_status(1'b0);
        expect_read(23'd5);
        req_read(23'd5);
        wait_quiet();

        // Reads during a download coalesce and wait behind the pending write.
        lat = 4;
        start_dl(8'd1);
        send(25'd20, 2);
        req_read(23'd5);
        req_read(23'd9);
        expect_read(23'd9);
        repeat (3) step();
        end_dl();
        wait_quiet();
        check_status(1'b0);

        // A few random reads of the loaded image.
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] ra;
            ra = AW'($urandom_range(0, 15));
            expect_read(ra);
            req_read(ra);
            wait_quiet();
        end

        // Reset while a write is outstanding.
        lat = 6;
        start_dl(8'd1);
        send(25'd3, 2);
        n = 0;
        while (!sdram_bus.we && n < 50) begin
            step();
            n++;
        end
        chk("we_seen", 32'(sdram_bus.we), 32'd1);
        step();
        reset_n = 1'b0;
        @(negedge clk_sys);
        check_all_zero("midreset");
        #1;
        ioctl_download = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2) step();
        lat = 3;
        start_dl(8'd1);
        for (int i = 0; i < 4; i++) send(25'(40 + i), 8);
        end_dl();
        wait_quiet();
        check_status(1'b0);
        chk("len_after_reset", 32'(tape_len), 32'd44);

        chk("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
